counter_scheduler: RTL and testbench

Time-multiplexed controller for the peripheral counter bank.
- Holds NUM_CNT counter slots: preset, accumulator, type, state.
- Accepts configure/start/stop/clear commands from the processor's peripheral write path.
- Services counting events from the I/O side with one shared update unit, granted round-robin one slot per cycle.
- Exposes per-slot DN/CU/CD status and a read port for the accumulators.

---
 rtl/counter_scheduler_pkg.sv | 47 ++++
 rtl/counter_slot_alu.sv | 25 ++
 rtl/counter_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_counter_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared widths, command/slot encodings and helpers for the counter bank.
// Optional feature macro: COUNTER_AUTORELOAD_EN (consumed by counter_scheduler).
`ifndef tcPresetLen
`define tcPresetLen 16
`endif
`ifndef tcAccLen
`define tcAccLen 16
`endif
`ifndef tcTypeLen
`define tcTypeLen 2
`endif
`ifndef counterType1
`define counterType1 2'b01
`endif
`ifndef counterType2
`define counterType2 2'b10
`endif

package counter_scheduler_pkg;

    localparam int unsigned PRESET_W = `tcPresetLen;
    localparam int unsigned ACC_W    = `tcAccLen;
    localparam int unsigned TYPE_W   = `tcTypeLen;

    localparam logic [TYPE_W-1:0] TYPE_UP   = `counterType1;
    localparam logic [TYPE_W-1:0] TYPE_DOWN = `counterType2;

    typedef enum logic [1:0] {
        CNT_OP_CONFIG = 2'b00,
        CNT_OP_START  = 2'b01,
        CNT_OP_STOP   = 2'b10,
        CNT_OP_CLEAR  = 2'b11
    } cnt_op_e;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'b00,
        SLOT_RUN  = 2'b01,
        SLOT_DONE = 2'b10
    } slot_state_e;

    // Accumulator start value: down counters begin at preset, up counters at zero.
    function automatic logic [ACC_W-1:0] reload_value(input logic is_down,
                                                      input logic [PRESET_W-1:0] preset);
        return is_down ? ACC_W'(preset) : '0;
    endfunction

endpackage

// File: rtl/counter_slot_alu.sv
// Shared update unit: next accumulator value and terminal-count detect for one slot.
module counter_slot_alu
    import counter_scheduler_pkg::*;
(
    input  logic [ACC_W-1:0]    acc,
    input  logic [PRESET_W-1:0] preset,
    input  logic                is_down,
    output logic [ACC_W-1:0]    acc_next,
    output logic                terminal
);

    // Saturating in both directions: up sticks at all-ones, down sticks at zero.
    always_comb begin
        acc_next = acc;
        terminal = 1'b0;
        if (is_down) begin
            if (acc != '0) acc_next = acc - ACC_W'(1);
            terminal = (acc_next == '0);
        end else begin
            if (acc != '1) acc_next = acc + ACC_W'(1);
            terminal = (acc_next == ACC_W'(preset));
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Time-multiplexed counter bank: slot register file, round-robin arbiter, command decode.
// Define COUNTER_AUTORELOAD_EN to reload and keep running at terminal count instead of stopping.
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CNT = 4,
    parameter int unsigned ID_W    = $clog2(NUM_CNT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [TYPE_W-1:0]   cmd_type,
    input  logic [PRESET_W-1:0] cmd_preset,
    input  logic [NUM_CNT-1:0]  evt,
    input  logic [ID_W-1:0]     rd_id,
    output logic [ACC_W-1:0]    rd_acc,
    output logic [NUM_CNT-1:0]  dn,
    output logic [NUM_CNT-1:0]  cu,
    output logic [NUM_CNT-1:0]  cd,
    output logic [NUM_CNT-1:0]  ovr
);

    slot_state_e         state_q  [NUM_CNT];
    slot_state_e         state_d  [NUM_CNT];
    logic [ACC_W-1:0]    acc_q    [NUM_CNT];
    logic [ACC_W-1:0]    acc_d    [NUM_CNT];
    logic [PRESET_W-1:0] preset_q [NUM_CNT];
    logic [PRESET_W-1:0] preset_d [NUM_CNT];
    logic [TYPE_W-1:0]   type_q   [NUM_CNT];
    logic [TYPE_W-1:0]   type_d   [NUM_CNT];
    logic [NUM_CNT-1:0]  pend_q, pend_d;
    logic [NUM_CNT-1:0]  dn_q, dn_d;
    logic [NUM_CNT-1:0]  ovr_q, ovr_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic                ready_q;

    cnt_op_e             op;
    logic                cmd_fire;
    logic [NUM_CNT-1:0]  eligible;
    logic [NUM_CNT-1:0]  grant_oh;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     scan_idx;

    logic [ACC_W-1:0]    alu_acc_next;
    logic                alu_terminal;

    assign op       = cnt_op_e'(cmd_op);
    assign cmd_fire = cmd_valid && ready_q;

    // A command to a slot masks it from arbitration this cycle, so the command always wins.
    always_comb begin
        eligible  = '0;
        grant_oh  = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            eligible[i] = pend_q[i] && (state_q[i] == SLOT_RUN);
        end
        if (cmd_fire) eligible[cmd_id] = 1'b0;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            scan_idx = rr_q + ID_W'(k);
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx;
            end
        end
        if (grant_vld) grant_oh[grant_id] = 1'b1;
    end

    counter_slot_alu u_alu (
        .acc      (acc_q[grant_id]),
        .preset   (preset_q[grant_id]),
        .is_down  (type_q[grant_id] == TYPE_DOWN),
        .acc_next (alu_acc_next),
        .terminal (alu_terminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                state_q[i]  <= SLOT_IDLE;
                acc_q[i]    <= '0;
                preset_q[i] <= '0;
                type_q[i]   <= TYPE_UP;
            end
            pend_q  <= '0;
            dn_q    <= '0;
            ovr_q   <= '0;
            rr_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            preset_q <= preset_d;
            type_q   <= type_d;
            pend_q   <= pend_d;
            dn_q     <= dn_d;
            ovr_q    <= ovr_d;
            rr_q     <= rr_d;
            ready_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        preset_d = preset_q;
        type_d   = type_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
`ifdef COUNTER_AUTORELOAD_EN
        dn_d     = '0;
`else
        dn_d     = dn_q;
`endif
        rr_d     = grant_vld ? grant_id + ID_W'(1) : rr_q;

        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (grant_oh[i]) begin
                pend_d[i] = 1'b0;
                acc_d[i]  = alu_acc_next;
                if (alu_terminal) begin
                    dn_d[i] = 1'b1;
`ifdef COUNTER_AUTORELOAD_EN
                    acc_d[i] = reload_value(type_q[i] == TYPE_DOWN, preset_q[i]);
`else
                    state_d[i] = SLOT_DONE;
`endif
                end
            end

            if (evt[i] && (state_q[i] == SLOT_RUN)) begin
                if (pend_q[i] && !grant_oh[i]) ovr_d[i] = 1'b1;
                else                           pend_d[i] = 1'b1;
            end

            if (cmd_fire && (cmd_id == ID_W'(i))) begin
                case (op)
                    CNT_OP_CONFIG: begin
                        type_d[i]   = (cmd_type == TYPE_DOWN) ? TYPE_DOWN : TYPE_UP;
                        preset_d[i] = cmd_preset;
                        acc_d[i]    = reload_value(cmd_type == TYPE_DOWN, cmd_preset);
                        dn_d[i]     = 1'b0;
                        pend_d[i]   = 1'b0;
                        ovr_d[i]    = 1'b0;
                        state_d[i]  = SLOT_IDLE;
                    end
                    CNT_OP_START: begin
                        if (state_q[i] == SLOT_IDLE) state_d[i] = SLOT_RUN;
                    end
                    CNT_OP_STOP: begin
                        if (state_q[i] == SLOT_RUN) state_d[i] = SLOT_IDLE;
                    end
                    CNT_OP_CLEAR: begin
                        acc_d[i]   = reload_value(type_q[i] == TYPE_DOWN, preset_q[i]);
                        dn_d[i]    = 1'b0;
                        pend_d[i]  = 1'b0;
                        ovr_d[i]   = 1'b0;
                        state_d[i] = SLOT_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cu = '0;
        cd = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            cu[i] = (state_q[i] == SLOT_RUN) && (type_q[i] == TYPE_UP);
            cd[i] = (state_q[i] == SLOT_RUN) && (type_q[i] == TYPE_DOWN);
        end
        rd_acc    = acc_q[rd_id];
        dn        = dn_q;
        ovr       = ovr_q;
        cmd_ready = ready_q;
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler; expectations follow COUNTER_AUTORELOAD_EN when defined.
module tb_counter_scheduler;
    import counter_scheduler_pkg::*;

`ifdef COUNTER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [1:0]          cmd_op = '0;
    logic [IW-1:0]       cmd_id = '0;
    logic [TYPE_W-1:0]   cmd_type = '0;
    logic [PRESET_W-1:0] cmd_preset = '0;
    logic [N-1:0]        evt = '0;
    logic [IW-1:0]       rd_id = '0;
    logic [ACC_W-1:0]    rd_acc;
    logic [N-1:0]        dn, cu, cd, ovr;

    int total = 0;
    int bad   = 0;

    counter_scheduler #(.NUM_CNT(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_id     (cmd_id),
        .cmd_type   (cmd_type),
        .cmd_preset (cmd_preset),
        .evt        (evt),
        .rd_id      (rd_id),
        .rd_acc     (rd_acc),
        .dn         (dn),
        .cu         (cu),
        .cd         (cd),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input int id,
                          input logic [TYPE_W-1:0] ty, input logic [PRESET_W-1:0] pre);
        cmd_op     = op;
        cmd_id     = IW'(id);
        cmd_type   = ty;
        cmd_preset = pre;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        evt = mask;
        tick();
        evt = '0;
    endtask

    task automatic rd(input int id, input string tag, input int exp);
        rd_id = IW'(id);
        #1;
        chk(tag, 32'(rd_acc), 32'(exp));
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_dn", 32'(dn), 0);
        chk("rst_cu_cd", 32'({cu, cd}), 0);
        rd(0, "rst_acc0", 0);
        reset = 1'b1;
        #1;
        chk("ready_before_edge", 32'(cmd_ready), 0);
        tick();
        chk("ready_after_edge", 32'(cmd_ready), 1);

        // up count, slot0 preset 3
        do_cmd(CNT_OP_CONFIG, 0, TYPE_UP, 3);
        rd(0, "up_cfg_acc", 0);
        do_cmd(CNT_OP_START, 0, '0, '0);
        chk("up_cu", 32'(cu[0]), 1);
        pulse(4'b0001);
        rd(0, "up_pend_latency", 0);
        tick();
        rd(0, "up_acc1", 1);
        pulse(4'b0001);
        tick();
        rd(0, "up_acc2", 2);
        chk("up_dn_early", 32'(dn[0]), 0);
        pulse(4'b0001);
        tick();
        rd(0, "up_acc3", AR ? 0 : 3);
        chk("up_dn", 32'(dn[0]), 1);
        chk("up_cu_after", 32'(cu[0]), AR ? 1 : 0);
        pulse(4'b0001);
        tick();
        rd(0, "up_post_evt", AR ? 1 : 3);
        chk("up_dn_hold", 32'(dn[0]), AR ? 0 : 1);

        // down count, slot1 preset 2
        do_cmd(CNT_OP_CONFIG, 1, TYPE_DOWN, 2);
        rd(1, "dn_cfg_acc", 2);
        do_cmd(CNT_OP_START, 1, '0, '0);
        chk("dn_cd", 32'(cd[1]), 1);
        pulse(4'b0010);
        tick();
        rd(1, "dn_acc1", 1);
        pulse(4'b0010);
        tick();
        rd(1, "dn_acc0", AR ? 2 : 0);
        chk("dn_flag", 32'(dn[1]), 1);
        chk("dn_cd_after", 32'(cd[1]), AR ? 1 : 0);
        tick();
        chk("dn_flag_next", 32'(dn[1]), AR ? 0 : 1);

        // arbitration: all slots up, preset 100
        for (int i = 0; i < 4; i++) do_cmd(CNT_OP_CONFIG, i, TYPE_UP, 100);
        for (int i = 0; i < 4; i++) do_cmd(CNT_OP_START, i, '0, '0);
        chk("arb_cu_all", 32'(cu), 32'hF);
        pulse(4'b1000);
        tick();
        rd(3, "arb_pre3", 1);
        pulse(4'b1111);
        tick();
        rd(0, "arb_g0_a0", 1);
        rd(1, "arb_g0_a1", 0);
        tick();
        rd(1, "arb_g1_a1", 1);
        rd(2, "arb_g1_a2", 0);
        tick();
        rd(2, "arb_g2_a2", 1);
        rd(3, "arb_g2_a3", 1);
        tick();
        rd(3, "arb_g3_a3", 2);
        pulse(4'b0010);
        tick();
        rd(1, "arb_single1", 2);
        pulse(4'b1111);
        tick();
        rd(2, "arb_b2_a2", 2);
        rd(0, "arb_b2_a0", 1);
        tick();
        rd(3, "arb_b2_a3", 3);
        rd(0, "arb_b2_a0b", 1);
        tick();
        rd(0, "arb_b2_a0c", 2);
        rd(1, "arb_b2_a1", 2);
        tick();
        rd(1, "arb_b2_a1b", 3);

        // overflow on slot2 while slot3 holds the grant
        pulse(4'b0100);
        tick();
        rd(2, "ovr_pre2", 3);
        evt = 4'b1100;
        tick();
        evt = 4'b0100;
        tick();
        evt = '0;
        chk("ovr_set", 32'(ovr), 32'h4);
        rd(3, "ovr_a3", 4);
        rd(2, "ovr_a2_wait", 3);
        tick();
        rd(2, "ovr_a2_once", 4);
        tick();
        rd(2, "ovr_a2_hold", 4);
        do_cmd(CNT_OP_CLEAR, 2, '0, '0);
        chk("ovr_cleared", 32'(ovr), 0);
        rd(2, "clr_acc2", 0);
        chk("clr_cu2", 32'(cu[2]), 0);

        // command/grant conflict on slot0
        pulse(4'b0001);
        do_cmd(CNT_OP_CLEAR, 0, '0, '0);
        rd(0, "conf_clr_acc", 0);
        chk("conf_clr_cu", 32'(cu[0]), 0);
        do_cmd(CNT_OP_START, 0, '0, '0);
        tick();
        tick();
        rd(0, "conf_dropped", 0);
        pulse(4'b0001);
        do_cmd(CNT_OP_STOP, 0, '0, '0);
        rd(0, "conf_stop_acc", 0);
        chk("conf_stop_cu", 32'(cu[0]), 0);
        tick();
        rd(0, "conf_idle_acc", 0);
        do_cmd(CNT_OP_START, 0, '0, '0);
        rd(0, "conf_start_acc", 0);
        tick();
        rd(0, "conf_held_evt", 1);

        // undefined type falls back to up
        do_cmd(CNT_OP_CONFIG, 3, 2'b11, 5);
        rd(3, "undef_acc", 0);
        do_cmd(CNT_OP_START, 3, '0, '0);
        chk("undef_cu", 32'(cu[3]), 1);
        chk("undef_cd", 32'(cd[3]), 0);
        chk("pre_rst_cu", 32'(cu), 32'hB);

        // asynchronous reset mid-run
        evt = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_dn", 32'(dn), 0);
        chk("arst_cu", 32'(cu), 0);
        chk("arst_cd", 32'(cd), 0);
        chk("arst_ovr", 32'(ovr), 0);
        chk("arst_ready", 32'(cmd_ready), 0);
        chk("arst_acc", 32'(rd_acc), 0);
        evt = '0;
        tick();
        reset = 1'b1;
        #1;
        chk("arst_ready_rel", 32'(cmd_ready), 0);
        tick();
        chk("arst_ready_edge", 32'(cmd_ready), 1);
        rd(1, "arst_acc1", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
